// File: rtl/npu_sync_array.sv
// Receive-side multi-channel synchronizer for NPU control/status lines: metastability
// chain, stability filter, mode-selected event pulse and sticky event/overflow flags.
module npu_sync_array #(
  parameter int unsigned      CH      = 4,
  parameter int unsigned      STAGES  = 2,
  parameter int unsigned      FILT    = 0,
  parameter logic [2*CH-1:0]  MODE    = {CH{2'b00}},
  parameter logic [CH-1:0]    RST_VAL = {CH{1'b0}}
) (
  input  logic          clk_cal,
  input  logic          rst,
  input  logic [CH-1:0] async_in,
  output logic [CH-1:0] sync_level,
  output logic [CH-1:0] sync_pulse,
  output logic [CH-1:0] evt_sticky,
  output logic [CH-1:0] evt_ovf,
  input  logic [CH-1:0] evt_clr
);

  localparam int unsigned   CW       = (FILT == 0) ? 1 : $clog2(FILT + 1);
  localparam logic [CW-1:0] FILT_MAX = CW'(FILT);

  localparam logic [1:0] MODE_RISE  = 2'b00;
  localparam logic [1:0] MODE_FALL  = 2'b01;
  localparam logic [1:0] MODE_BOTH  = 2'b10;
  localparam logic [1:0] MODE_LEVEL = 2'b11;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      localparam logic [1:0] CH_MODE = MODE[2*gi +: 2];

      logic [STAGES-1:0] chain_reg;
      logic              so;
      logic [CW-1:0]     cnt_reg, cnt_next;
      logic              level_reg, level_next;
      logic              pulse_reg, pulse_next;
      logic              sticky_reg, sticky_next;
      logic              ovf_reg, ovf_next;
      logic              update;

      // Only chain_reg[0] may go metastable; nothing but the shift reads the inner stages.
      always_ff @(posedge clk_cal or posedge rst) begin
        if (rst) begin
          chain_reg <= {STAGES{RST_VAL[gi]}};
        end else begin
          chain_reg <= {chain_reg[STAGES-2:0], async_in[gi]};
        end
      end

      assign so = chain_reg[STAGES-1];

      // A new value is accepted only after FILT+1 consecutive cycles of disagreement.
      always_comb begin
        cnt_next   = '0;
        level_next = level_reg;
        update     = 1'b0;
        if (so != level_reg) begin
          if (cnt_reg == FILT_MAX) begin
            update     = 1'b1;
            level_next = so;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      always_comb begin
        case (CH_MODE)
          MODE_RISE:  pulse_next = update & so;
          MODE_FALL:  pulse_next = update & ~so;
          MODE_BOTH:  pulse_next = update;
          MODE_LEVEL: pulse_next = 1'b0;
          default:    pulse_next = 1'b0;
        endcase
      end

      // A pulse always wins over a clear; overflow only sets when nobody is clearing.
      assign sticky_next = pulse_reg | (sticky_reg & ~evt_clr[gi]);
      assign ovf_next    = (pulse_reg & sticky_reg & ~evt_clr[gi]) | (ovf_reg & ~evt_clr[gi]);

      always_ff @(posedge clk_cal or posedge rst) begin
        if (rst) begin
          cnt_reg    <= '0;
          level_reg  <= RST_VAL[gi];
          pulse_reg  <= 1'b0;
          sticky_reg <= 1'b0;
          ovf_reg    <= 1'b0;
        end else begin
          cnt_reg    <= cnt_next;
          level_reg  <= level_next;
          pulse_reg  <= pulse_next;
          sticky_reg <= sticky_next;
          ovf_reg    <= ovf_next;
        end
      end

      assign sync_level[gi] = level_reg;
      assign sync_pulse[gi] = pulse_reg;
      assign evt_sticky[gi] = sticky_reg;
      assign evt_ovf[gi]    = ovf_reg;
    end
  endgenerate

endmodule

// File: tb/tb_npu_sync_array.sv
// Directed reset/latency/mode/sticky/reversal steps on several configurations, then a
// randomized run of one configuration against a sample-window reference model.
`timescale 1ns/1ps
module tb_npu_sync_array;

  localparam logic [7:0] A_MODE   = 8'b11_10_01_00;
  localparam logic [3:0] A_RST    = 4'b1010;
  localparam int         C_STAGES = 3;
  localparam int         C_FILT   = 2;
  localparam logic [7:0] C_MODE   = 8'b00_11_10_01;
  localparam logic [3:0] C_RST    = 4'b0110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] a_in, a_clr, a_lvl, a_pls, a_stk, a_ovf;
  logic [3:0] b_in, b_clr, b_lvl, b_pls, b_stk, b_ovf;
  logic [3:0] c_in, c_clr, c_lvl, c_pls, c_stk, c_ovf;
  logic [3:0] d_in, d_clr, d_lvl, d_pls, d_stk, d_ovf;

  npu_sync_array #(.CH(4), .STAGES(2), .FILT(0), .MODE(A_MODE), .RST_VAL(A_RST)) u_a (
    .clk_cal(clk), .rst(rst), .async_in(a_in), .sync_level(a_lvl), .sync_pulse(a_pls),
    .evt_sticky(a_stk), .evt_ovf(a_ovf), .evt_clr(a_clr));

  npu_sync_array #(.CH(4), .STAGES(2), .FILT(3), .MODE(8'h00), .RST_VAL(4'b0000)) u_b (
    .clk_cal(clk), .rst(rst), .async_in(b_in), .sync_level(b_lvl), .sync_pulse(b_pls),
    .evt_sticky(b_stk), .evt_ovf(b_ovf), .evt_clr(b_clr));

  npu_sync_array #(.CH(4), .STAGES(C_STAGES), .FILT(C_FILT), .MODE(C_MODE), .RST_VAL(C_RST)) u_c (
    .clk_cal(clk), .rst(rst), .async_in(c_in), .sync_level(c_lvl), .sync_pulse(c_pls),
    .evt_sticky(c_stk), .evt_ovf(c_ovf), .evt_clr(c_clr));

  npu_sync_array #(.CH(4), .STAGES(2), .FILT(4), .MODE(8'h00), .RST_VAL(4'b0000)) u_d (
    .clk_cal(clk), .rst(rst), .async_in(d_in), .sync_level(d_lvl), .sync_pulse(d_pls),
    .evt_sticky(d_stk), .evt_ovf(d_ovf), .evt_clr(d_clr));

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt += 1;
    assert (obs === exp) pass_cnt += 1;
    else begin
      fail_cnt += 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model state for u_c
  logic [3:0] hq[$];
  logic [3:0] m_lvl, m_pls, m_stk, m_ovf, old_pls, old_stk;
  logic [7:0] c_mode;
  int         pc[4];
  int         first_high, rev_pulses;
  logic       glitch_seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    a_in = A_RST; a_clr = '0;
    b_in = '0;    b_clr = '0;
    c_in = '0;    c_clr = '0;
    d_in = '0;    d_clr = '0;
    c_mode = C_MODE;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(5);

    // ---- reset values and post-reset update on u_a ----
    chk("a_idle_level", a_lvl, A_RST);
    chk("a_idle_pulse", a_pls, 4'b0000);
    a_in = 4'b0101;
    tick(2);
    chk("a_pre_level", a_lvl, A_RST);
    tick(1);
    chk("a_upd_level", a_lvl, 4'b0101);
    chk("a_upd_pulse", a_pls, 4'b0111);
    tick(1);
    chk("a_pulse_width", a_pls, 4'b0000);
    chk("a_sticky_set", a_stk, 4'b0111);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_level", a_lvl, A_RST);
    chk("rst_async_pulse", a_pls, 4'b0000);
    chk("rst_async_sticky", a_stk, 4'b0000);
    chk("rst_async_ovf", a_ovf, 4'b0000);
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("rel_pre_level", a_lvl, A_RST);
    chk("rel_pre_pulse", a_pls, 4'b0000);
    tick(1);
    chk("rel_upd_level", a_lvl, 4'b0101);
    chk("rel_upd_pulse", a_pls, 4'b0111);

    // ---- pulse modes with a 20-cycle square wave ----
    a_in = 4'b0000;
    tick(6);
    a_clr = 4'hF;
    tick(1);
    a_clr = 4'h0;
    for (int ch = 0; ch < 4; ch++) pc[ch] = 0;
    for (int p = 0; p < 3; p++) begin
      for (int h = 0; h < 2; h++) begin
        a_in = (h == 0) ? 4'hF : 4'h0;
        for (int k = 0; k < 10; k++) begin
          tick(1);
          for (int ch = 0; ch < 4; ch++) if (a_pls[ch]) pc[ch]++;
        end
        chk("mode_level_track", a_lvl, a_in);
      end
    end
    chk("mode_rise_count", pc[0], 3);
    chk("mode_fall_count", pc[1], 3);
    chk("mode_both_count", pc[2], 6);
    chk("mode_level_count", pc[3], 0);

    // ---- sticky / overflow on u_a channel 0 (rise mode) ----
    a_clr = 4'hF;
    tick(1);
    a_clr = 4'h0;
    chk("stk_cleared", a_stk, 4'b0000);
    chk("ovf_cleared", a_ovf, 4'b0000);
    a_in = 4'b0001; tick(5);
    chk("stk_first", a_stk, 4'b0001);
    chk("ovf_first", a_ovf, 4'b0000);
    a_in = 4'b0000; tick(5);
    a_in = 4'b0001; tick(5);
    chk("stk_second", a_stk, 4'b0001);
    chk("ovf_second", a_ovf, 4'b0001);
    a_clr = 4'b0001; tick(1); a_clr = 4'b0000;
    chk("clr_alone_stk", a_stk, 4'b0000);
    chk("clr_alone_ovf", a_ovf, 4'b0000);
    a_in = 4'b0000; tick(4);
    a_in = 4'b0001; tick(5);
    a_in = 4'b0000; tick(4);
    a_in = 4'b0001; tick(3);
    chk("coin_pulse", a_pls, 4'b0001);
    chk("coin_pre_stk", a_stk, 4'b0001);
    a_clr = 4'b0001; tick(1); a_clr = 4'b0000;
    chk("coin_stk", a_stk, 4'b0001);
    chk("coin_ovf", a_ovf, 4'b0000);

    // ---- latency and glitch filter on u_b (STAGES=2, FILT=3) ----
    b_in = 4'b0001;
    tick(5);
    chk("lat_before_level", b_lvl, 4'b0000);
    chk("lat_before_pulse", b_pls, 4'b0000);
    tick(1);
    chk("lat_level", b_lvl, 4'b0001);
    chk("lat_pulse", b_pls, 4'b0001);
    tick(1);
    chk("lat_pulse_width", b_pls, 4'b0000);
    b_in = 4'b0111; tick(3);
    b_in = 4'b0101; tick(1);
    b_in = 4'b0001;
    glitch_seen = 1'b0;
    pc[1] = 0; pc[2] = 0;
    for (int k = 0; k < 14; k++) begin
      tick(1);
      if (b_lvl[1] || b_pls[1]) glitch_seen = 1'b1;
      if (b_pls[2]) pc[2]++;
    end
    chk("glitch3_suppressed", glitch_seen, 1'b0);
    chk("glitch4_accepted", pc[2], 1);

    // ---- reversal on u_d (FILT=4): high 3, low 1, high 5 ----
    first_high = -1;
    rev_pulses = 0;
    for (int i = 0; i < 25; i++) begin
      d_in[0] = (i < 3) || (i >= 4 && i < 9);
      tick(1);
      if (d_pls[0]) rev_pulses++;
      if (d_lvl[0] && first_high < 0) first_high = i;
    end
    chk("rev_update_cycle", first_high, 10);
    chk("rev_single_pulse", rev_pulses, 1);

    // ---- random stimulus on u_c against the window model ----
    c_in = C_RST; c_clr = '0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m_lvl = C_RST; m_pls = '0; m_stk = '0; m_ovf = '0;
    hq.delete();
    repeat (C_STAGES + C_FILT + 1) hq.push_back(C_RST);
    for (int cyc = 0; cyc < 10000; cyc++) begin
      chk("rnd_level", c_lvl, m_lvl);
      chk("rnd_pulse", c_pls, m_pls);
      chk("rnd_sticky", c_stk, m_stk);
      chk("rnd_ovf", c_ovf, m_ovf);
      for (int ch = 0; ch < 4; ch++) begin
        if ($urandom_range(3) == 0) c_in[ch] = ~c_in[ch];
        c_clr[ch] = ($urandom_range(7) == 0);
      end
      @(posedge clk);
      old_pls = m_pls;
      old_stk = m_stk;
      hq.push_back(c_in);
      if (hq.size() > 8) void'(hq.pop_front());
      for (int ch = 0; ch < 4; ch++) begin
        logic tgt;
        logic stable;
        logic [1:0] md;
        // The level flips once the chain output has shown the opposite value
        // for FILT+1 consecutive samples; sample n reaches the filter STAGES edges later.
        tgt = ~m_lvl[ch];
        stable = 1'b1;
        for (int j = C_STAGES; j <= C_STAGES + C_FILT; j++)
          if (hq[hq.size() - 1 - j][ch] != tgt) stable = 1'b0;
        md = c_mode[2*ch +: 2];
        if (old_pls[ch]) m_stk[ch] = 1'b1;
        else if (c_clr[ch]) m_stk[ch] = 1'b0;
        if (old_pls[ch] && old_stk[ch] && !c_clr[ch]) m_ovf[ch] = 1'b1;
        else if (c_clr[ch]) m_ovf[ch] = 1'b0;
        m_pls[ch] = 1'b0;
        if (stable) begin
          m_lvl[ch] = tgt;
          case (md)
            2'b00:   m_pls[ch] = tgt;
            2'b01:   m_pls[ch] = ~tgt;
            2'b10:   m_pls[ch] = 1'b1;
            default: m_pls[ch] = 1'b0;
          endcase
        end
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/npu_sync_array.md
Name: npu_sync_array

Overview:
- Parametrised, multi-channel receive-side synchronizer for NPU control/status signals: `npu_en_processing`, `npu_init_cmplt`, `npu_busy` and the next-generation status lines.
- One instance sits in each destination clock domain.
- Per channel it provides a configurable-depth metastability chain, a stability (glitch) filter, a mode-selected event pulse and a sticky event flag with overflow detection.
- Replaces the hand-written fixed 2/3-flop chains for new signals.

Parameters:
- CH, 4: number of independent channels (1..32).
- STAGES, 2: synchronizer flop depth per channel (2..4).
- FILT, 0: extra consecutive cycles a new synchronized value must persist before being accepted (0..255).
- MODE, {CH{2'b00}}: packed 2 bits per channel, channel i at [2i+1:2i]. 00 = rise pulse, 01 = fall pulse, 10 = both-edge pulse, 11 = level only (no pulse).
- RST_VAL, {CH{1'b0}}: per-channel reset value of the sync chain and the filtered level.

Ports:
- clk_cal  input  1  destination-domain clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- async_in  input  CH  asynchronous inputs from the source domain; each bit must be driven from a flop in the source domain.
- sync_level  output  CH  filtered, synchronized level.
- sync_pulse  output  CH  one-cycle event pulse per MODE.
- evt_sticky  output  CH  sticky event flag.
- evt_ovf  output  CH  sticky overflow flag.
- evt_clr  input  CH  per-channel clear for evt_sticky and evt_ovf (synchronous to clk_cal).

Behaviour:
- Reset (async assert, sync release by top-level reset logic):
  - sync chain bits = RST_VAL[i]; sync_level = RST_VAL.
  - Filter counters = 0; sync_pulse = 0; evt_sticky = 0; evt_ovf = 0.
- Sync chain: s[0] <= async_in[i], s[k] <= s[k-1]. The chain output `so` = s[STAGES-1]. Only s[0] may go metastable; no logic reads s[0..STAGES-2].
- Filter, per channel (counter width clog2(FILT+1), min 1):
  - so == sync_level: cnt <= 0.
  - so != sync_level and cnt < FILT: cnt <= cnt+1.
  - so != sync_level and cnt == FILT: sync_level <= so, cnt <= 0. This is the "update" cycle.
  - A change on `so` lasting fewer than FILT+1 cycles is suppressed, with no pulse and no level change.
  - An alternating `so` restarts the count on every reversal.
- Latency: input stable before edge 0 → sync_level changes at edge STAGES+FILT+1. The bench allows ±1 cycle of CDC uncertainty at edge 0.
- sync_pulse (registered, asserts the same cycle sync_level takes its new value, exactly 1 cycle wide):
  - Rise mode: on update with new value 1.
  - Fall mode: on update with new value 0.
  - Both-edge mode: on every update.
  - Level-only mode: constant 0.
  - Back-to-back updates are at least FILT+1 cycles apart, so consecutive pulses are never merged.
- Sticky flags, per channel, evaluated each edge:
  - evt_sticky: sync_pulse & evt_clr → 1 (set wins); evt_clr alone → 0; sync_pulse alone → 1.
  - evt_ovf: sets when sync_pulse while evt_sticky==1 and evt_clr==0; cleared only by evt_clr (set wins on the same cycle only under the ovf condition above).
- Channels are fully independent; MODE/FILT/STAGES are static.
- Reset mid-operation:
  - Pending filter counts and pulses are discarded and no pulse is emitted on reset.
  - After release, if async_in[i] != RST_VAL[i], the channel updates and pulses normally after STAGES+FILT+1 cycles.
- No combinational path from any input to any output.

Test Plan:
- Reset values: CH=4, RST_VAL=4'b1010, assert rst mid-stream with async_in=4'b0101 → outputs immediately sync_level=1010, sync_pulse/evt_sticky/evt_ovf=0. After release, channels 0 and 2 rise and channels 1 and 3 fall at cycle STAGES+FILT+1 (=3 for defaults), with pulses per MODE.
- Latency/filter: STAGES=2, FILT=3, async_in[0] 0→1 held → sync_level[0] rises exactly 6 edges later with a 1-cycle sync_pulse[0] (rise mode). A 3-cycle high glitch → no level change, no pulse.
- Modes: MODE={11,10,01,00}, drive square wave period 20 → ch0 pulses on rises only, ch1 on falls only, ch2 on both edges, ch3 never; sync_level tracks on all channels.
- Sticky/overflow: two rise events on ch0 without clear → evt_sticky=1 after first, evt_ovf=1 after second. Pulse coincident with evt_clr → evt_sticky stays 1, evt_ovf stays 0. evt_clr alone → both 0 next cycle.
- Reversal: FILT=4, `so` high 3 cycles, low 1, high 5 → single update only after the final 5-cycle run; exactly one pulse.
- Random async_in over 10k cycles vs. reference model with STAGES=3, FILT=2 → cycle-exact match of all outputs, allowing the ±1-cycle capture window on each input edge.
